// File: rtl/cpu_pkg.sv
// cpu_pkg: shared ALU constants and types.
//   DATA_W      - datapath width (32)
//   DIV_ITERS   - restoring-division iterations, one quotient bit each
//   DIV_CNT_W   - width of the iteration counter
//   div_state_t - divider FSM states (IDLE, CALC, FIX)
//   mag()       - two's-complement magnitude with 32-bit wraparound
package cpu_pkg;

    localparam int DATA_W    = 32;
    localparam int DIV_ITERS = 32;
    localparam int DIV_CNT_W = $clog2(DIV_ITERS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    // |v| with wraparound: the most negative value maps to itself.
    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/sub32.sv
// sub32: 32-bit subtractor, diff = a - b computed as a + ~b + cin.
//   a, b  in  32 : operands
//   cin   in  1  : carry-in (1 for a true subtraction)
//   diff  out 32 : difference
//   cout  out 1  : carry-out, high when no borrow occurred (a >= b for cin=1)
module sub32
    import cpu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] diff,
    output logic              cout
);

    assign {cout, diff} = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, cin};

endmodule

// File: rtl/div32.sv
// div32: iterative signed 32-bit restoring divider, one quotient bit per clock.
//   clock     in  1  : rising-edge clock
//   clear     in  1  : synchronous active-low reset
//   start     in  1  : request a division (sampled only while idle)
//   dividend  in  32 : signed dividend, sampled with start
//   divisor   in  32 : signed divisor, sampled with start
//   quotient  out 32 : signed quotient, truncated toward zero
//   remainder out 32 : signed remainder, sign follows dividend
//   busy      out 1  : division in progress
//   done      out 1  : one-cycle pulse when results are written
//   div_zero  out 1  : divisor was zero; held with the results
module div32
    import cpu_pkg::*;
(
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              busy,
    output logic              done,
    output logic              div_zero
);

    div_state_t           state, next_state;
    logic [DATA_W-1:0]    q, d, r, raw;
    logic [DIV_CNT_W-1:0] count;
    logic                 neg_q, neg_r, dz;

    // Trial subtraction on the 33-bit shifted partial remainder {top, x}.
    // When the bit shifted out of R is set the shifted value already exceeds
    // D, so the 32-bit difference is taken regardless of the borrow.
    logic              top;
    logic [DATA_W-1:0] x, diff;
    logic              no_borrow, take;

    assign top  = r[DATA_W-1];
    assign x    = {r[DATA_W-2:0], q[DATA_W-1]};
    assign take = top | no_borrow;

    sub32 u_sub (
        .a    (x),
        .b    (d),
        .cin  (1'b1),
        .diff (diff),
        .cout (no_borrow)
    );

    always_comb begin
        next_state = state;
        busy       = (state != IDLE);
        case (state)
            IDLE:    if (start) next_state = CALC;
            CALC:    if (count == DIV_CNT_W'(DIV_ITERS - 1)) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state     <= IDLE;
            q         <= '0;
            d         <= '0;
            r         <= '0;
            raw       <= '0;
            count     <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            dz        <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            state <= next_state;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        q     <= mag(dividend);
                        d     <= mag(divisor);
                        r     <= '0;
                        count <= '0;
                        neg_q <= dividend[DATA_W-1] ^ divisor[DATA_W-1];
                        neg_r <= dividend[DATA_W-1];
                        dz    <= (divisor == '0);
                        raw   <= dividend;
                    end
                end
                CALC: begin
                    r     <= take ? diff : x;
                    q     <= {q[DATA_W-2:0], take};
                    count <= count + 1'b1;
                end
                FIX: begin
                    if (dz) begin
                        quotient  <= '1;
                        remainder <= raw;
                        div_zero  <= 1'b1;
                    end else begin
                        quotient  <= neg_q ? (~q + 1'b1) : q;
                        remainder <= neg_r ? (~r + 1'b1) : r;
                        div_zero  <= 1'b0;
                    end
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div32.sv
module tb_div32;

    logic        clock;
    logic        clear;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        div_zero;

    int tests;
    int fails;

    div32 dut (
        .clock     (clock),
        .clear     (clear),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed arithmetic in 64 bits, so the overflow case
    // wraps naturally when truncated back to 32 bits.
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic z);
        longint sa, sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
            z  = 1'b0;
        end
    endtask

    // Run one division; ign > 0 pulses a second start (8/2) on that cycle.
    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b, input int ign);
        logic [31:0] eq, er;
        logic        ez;
        int          n;
        int          pulses;
        model(a, b, eq, er, ez);
        @(negedge clock);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        chk({tag, " busy_rise"}, 32'(busy), 32'd1);
        n = 0;
        pulses = 0;
        while (n < 60 && pulses == 0) begin
            if (ign > 0 && n == ign) begin
                dividend = 32'd8;
                divisor  = 32'd2;
                start    = 1'b1;
            end
            @(posedge clock); #1;
            start = 1'b0;
            n++;
            if (done) pulses++;
        end
        chk({tag, " latency"}, 32'(n), 32'd33);
        chk({tag, " quotient"}, quotient, eq);
        chk({tag, " remainder"}, remainder, er);
        chk({tag, " div_zero"}, 32'(div_zero), 32'(ez));
        chk({tag, " busy_fall"}, 32'(busy), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            if (done) pulses++;
        end
        chk({tag, " one_pulse"}, 32'(pulses), 32'd1);
        chk({tag, " held_q"}, quotient, eq);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          nd;
        tests    = 0;
        fails    = 0;
        clear    = 1'b0;
        start    = 1'b1;
        dividend = 32'd5;
        divisor  = 32'd1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst quotient", quotient, 32'd0);
        chk("rst remainder", remainder, 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst div_zero", 32'(div_zero), 32'd0);
        @(negedge clock);
        start = 1'b0;
        clear = 1'b1;

        do_div("100/7", 32'd100, 32'd7, 0);
        do_div("-100/7", -32'sd100, 32'd7, 0);
        do_div("100/-7", 32'd100, -32'sd7, 0);
        do_div("min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_div("min/1", 32'h8000_0000, 32'd1, 0);
        do_div("55/0", 32'd55, 32'd0, 0);
        do_div("9/3", 32'd9, 32'd3, 0);
        do_div("1000/3 ign", 32'd1000, 32'd3, 10);

        // Reset in the middle of a division.
        @(negedge clock);
        dividend = 32'd1234;
        divisor  = 32'd5;
        start    = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (14) @(posedge clock);
        @(negedge clock);
        clear = 1'b0;
        @(posedge clock); #1;
        chk("abort quotient", quotient, 32'd0);
        chk("abort remainder", remainder, 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort div_zero", 32'(div_zero), 32'd0);
        @(negedge clock);
        clear = 1'b1;
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock); #1;
            if (done) nd++;
        end
        chk("abort no_done", 32'(nd), 32'd0);
        do_div("20/6", 32'd20, 32'd6, 0);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'($urandom_range(1, 20));
                1:       rb = -32'($urandom_range(1, 20));
                2:       rb = (i % 5 == 0) ? 32'd0 : $urandom;
                default: rb = $urandom;
            endcase
            if (i % 4 == 1) ra = -ra;
            do_div("rand", ra, rb, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
